// File: rtl/wb_master.sv
// Single-outstanding pipelined Wishbone initiator: bridges a valid/ready core
// request port onto the bus and turns a missing ACK into an error response.
module wb_master #(
  parameter int BYTES   = 32,
  parameter int MASK    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req_valid,
  input  logic             i_req_we,
  input  logic [BYTES-1:0] i_req_addr,
  input  logic [BYTES-1:0] i_req_data,
  input  logic [MASK-1:0]  i_req_sel,
  output logic             o_req_ready,
  output logic             o_rsp_valid,
  output logic [BYTES-1:0] o_rsp_data,
  output logic             o_rsp_err,
  output logic             o_cyc,
  output logic             o_stb,
  output logic             o_we,
  output logic [BYTES-1:0] o_addr,
  output logic [BYTES-1:0] o_data,
  output logic [MASK-1:0]  o_sel,
  input  logic             i_stall,
  input  logic             i_ack,
  input  logic             i_err,
  input  logic [BYTES-1:0] i_data
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_C  = CW'(TIMEOUT);
  localparam logic [CW-1:0] ONE_C = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [BYTES-1:0] addr_q, addr_d;
  logic [BYTES-1:0] wdata_q, wdata_d;
  logic [MASK-1:0]  sel_q, sel_d;
  logic             cyc_q, cyc_d;
  logic             stb_q, stb_d;
  logic             ready_q, ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [BYTES-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;

  // Next-state, bus latch, timeout counter and response capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    sel_d      = sel_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (i_req_valid) begin
          we_d    = i_req_we;
          addr_d  = i_req_addr;
          wdata_d = i_req_data;
          sel_d   = i_req_sel;
          cnt_d   = {CW{1'b0}};
          state_d = ST_STROBE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STROBE: begin
        if (cnt_q == TO_C) begin
          rsp_data_d = {BYTES{1'b0}};
          rsp_err_d  = 1'b1;
          state_d    = ST_RESP;
        end else if (!i_stall) begin
          cnt_d   = cnt_q + ONE_C;
          state_d = ST_WAIT;
        end else begin
          cnt_d   = cnt_q + ONE_C;
          state_d = ST_STROBE;
        end
      end
      ST_WAIT: begin
        // ERR wins when the slave raises both terminations together.
        if (i_err) begin
          rsp_data_d = {BYTES{1'b0}};
          rsp_err_d  = 1'b1;
          state_d    = ST_RESP;
        end else if (i_ack) begin
          rsp_data_d = we_q ? {BYTES{1'b0}} : i_data;
          rsp_err_d  = 1'b0;
          state_d    = ST_RESP;
        end else if (cnt_q == TO_C) begin
          rsp_data_d = {BYTES{1'b0}};
          rsp_err_d  = 1'b1;
          state_d    = ST_RESP;
        end else begin
          cnt_d   = cnt_q + ONE_C;
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cyc_d       = (state_d == ST_STROBE) || (state_d == ST_WAIT);
    stb_d       = (state_d == ST_STROBE);
    ready_d     = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  // State and output registers; reset drops the bus cycle immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CW{1'b0}};
      we_q        <= 1'b0;
      addr_q      <= {BYTES{1'b0}};
      wdata_q     <= {BYTES{1'b0}};
      sel_q       <= {MASK{1'b0}};
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= {BYTES{1'b0}};
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign o_req_ready = ready_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_cyc       = cyc_q;
  assign o_stb       = stb_q;
  assign o_we        = we_q;
  assign o_addr      = addr_q;
  assign o_data      = wdata_q;
  assign o_sel       = sel_q;

endmodule

// File: doc/wb_master.md
# wb_master

Single-outstanding Wishbone (pipelined) bus initiator that bridges a simple valid/ready request/response port from the CPU core onto the system bus. It drives CYC/STB/WE/ADDR/DATA/SEL toward slaves such as the on-chip memory and LED/UART peripherals. It honours slave stall, collects ACK/ERR and read data, and converts a missing acknowledge into an error response after a bounded timeout.

## Interface

Parameters:
- BYTES, 32, address and data width in bits.
- MASK, 4, number of byte-select lanes (BYTES/MASK bits per lane).
- TIMEOUT, 255, maximum cycles from bus-cycle start to ACK/ERR before abort; must be ≥ 2.

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_req_valid  input  1  core presents a request.
- i_req_we  input  1  0 = read, 1 = write.
- i_req_addr  input  BYTES  byte address, forwarded unchanged.
- i_req_data  input  BYTES  write data.
- i_req_sel  input  MASK  byte lanes.
- o_req_ready  output  1  request accepted when valid && ready.
- o_rsp_valid  output  1  one-cycle response pulse.
- o_rsp_data  output  BYTES  read data; 0 for writes and errors.
- o_rsp_err  output  1  qualifies o_rsp_valid: slave ERR or timeout.
- o_cyc  output  1  bus cycle in progress.
- o_stb  output  1  strobe, slave selected.
- o_we  output  1  bus direction.
- o_addr  output  BYTES  bus address.
- o_data  output  BYTES  bus write data.
- o_sel  output  MASK  bus byte selects.
- i_stall  input  1  slave cannot accept strobe this cycle.
- i_ack  input  1  normal termination.
- i_err  input  1  error termination.
- i_data  input  BYTES  slave read data, valid with i_ack.

## Operation

- FSM states: IDLE, STROBE, WAIT, RESP. o_req_ready = (state == IDLE).
- IDLE: on i_req_valid, latch we/addr/data/sel into bus registers, clear timeout counter, go STROBE.
- STROBE: o_cyc=1, o_stb=1. If !i_stall, strobe accepted → WAIT. Otherwise remain, holding all bus outputs stable.
- WAIT: o_cyc=1, o_stb=0. On i_ack: capture i_data if read (0 if write), err=0 → RESP. On i_err: data=0, err=1 → RESP. i_ack and i_err together: treated as error.
- Timeout: counter increments each cycle in STROBE or WAIT; when it reaches TIMEOUT without termination, drop o_cyc/o_stb, err=1, data=0 → RESP.
- ACK/ERR sampled only in WAIT; any arriving in IDLE, STROBE or RESP is ignored (no response generated).
- RESP: o_rsp_valid=1 one cycle, o_cyc=0 → IDLE. No backpressure on response; core must accept it.
- o_we/o_addr/o_data/o_sel hold last request values outside active cycles; o_data not zeroed on reads.
- Reset (async, any state): state=IDLE, o_cyc=o_stb=o_we=0, o_addr=o_data=0, o_sel=0, o_rsp_valid=0, o_rsp_data=0, o_rsp_err=0, counter=0. Reset mid-transaction aborts with no response; outputs deasserted immediately, not at next edge.

## Timing

- Accept edge T0 (valid && ready). o_cyc/o_stb high in cycle T0+1.
- Zero-stall slave with registered ACK (ACK one cycle after strobe): ACK in T0+2, o_rsp_valid in T0+3, o_req_ready back high T0+4. Throughput: one transaction per 4 cycles.
- Each stall cycle adds one cycle; each ACK wait cycle adds one cycle.
- STB held for exactly one non-stalled cycle per transaction; never re-asserted before termination.
- o_cyc drops the cycle after termination (in RESP), never while STB is high.
- Timeout: error response pulse in cycle T0+TIMEOUT+2.

## Test plan

- Write then read, zero-stall memory model: write 0xDEADBEEF sel=4'hF to 0x190, read 0x190 → writes respond err=0 data=0, read responds data=0xDEADBEEF, o_rsp_valid exactly T0+3 each time.
- Byte write: preload 0x11223344 at 0x0, write 0x000000AA sel=4'b0001, read back → 0x112233AA.
- Stall: i_stall high 3 cycles after STB → addr/data/sel/we stable throughout, STB high 4 cycles total, response at T0+6.
- Slave ERR: i_err one cycle after strobe on read of 0x8 → o_rsp_valid with o_rsp_err=1, o_rsp_data=0; o_cyc low in response cycle.
- Timeout with TIMEOUT=8, no ACK → o_cyc drops, err response at T0+10; a later spurious i_ack in IDLE produces no pulse; next request completes normally.
- Async reset asserted mid-WAIT → o_cyc/o_stb low before next edge, no response pulse, o_req_ready high after release.
